spi_reg_slave: RTL
==================

// Module: spi_reg_slave
// PURPOSE
//  SPI mode-0 responder (CPOL=0, CPHA=0) exposing a 32x8 register file to an external SPI master.
//  Uses a MAX3421E-style framing:
//   - byte 0: command, with reg = cmd[7:3], dir = cmd[1] (1 = write), cmd[0] ignored.
//   - following bytes: data to/from that register. No auto-increment.
//  Serves as the far-end model / FPGA-side peer of the SoC SPI master. Gives local fabric access to the same registers.
// PARAMETERS
//  STATUS_REG  5'd24  register returned on MISO during the command byte
//  IRQ_REG     5'd25  interrupt flag register
//  IEN_REG     5'd26  interrupt enable register
// PORTS
//  clk_clk       in   1  system clock; all logic, incl. SPI pins, sampled in this domain
//  reset_reset   in   1  asynchronous, active-high reset
//  spi_sclk      in   1  SPI clock from master (async)
//  spi_mosi      in   1  SPI data in (async)
//  spi_ss_n      in   1  SPI select, active low (async)
//  spi_miso      out  1  SPI data out
//  spi_miso_oe   out  1  MISO output enable; top level tri-states when 0
//  loc_addr      in   5  local register address
//  loc_wdata     in   8  local write data
//  loc_we        in   1  local write strobe, one cycle
//  loc_rdata     out  8  regs[loc_addr], combinational
//  spi_wr_valid  out  1  1-cycle pulse: SPI wrote a register
//  spi_wr_addr   out  5  address of that write (valid with pulse)
//  spi_wr_data   out  8  data of that write (valid with pulse)
//  irq           out  1  |(regs[IRQ_REG] & regs[IEN_REG]), registered
// BEHAVIOUR
//  Reset values:
//   - regs all 0x00; state IDLE.
//   - spi_miso = 0, spi_miso_oe = 0, spi_wr_valid = 0, irq = 0.
//  Input synchronisation:
//   - sclk, mosi, ss_n each pass a 2-FF synchroniser, then a registered edge detector.
//   - Supported SCLK <= clk_clk/8.
//  Output enable: spi_miso_oe = ~ss_n_sync. spi_miso = tx_shift[7].
//  State machine (states IDLE, CMD, WR, RD):
//   - IDLE -> CMD on ss_n fall: tx_shift <= regs[STATUS_REG], bit_cnt <= 0. MSB is on MISO within 4 clk of the pin edge.
//   - Each SCLK rise: rx_shift <= {rx_shift[6:0], mosi}; bit_cnt++ (3-bit, wraps 7 -> 0).
//   - On the rise completing bit 7:
//     - In CMD: addr <= rx[7:3]; go to WR if rx[1], else RD.
//     - In WR: regs[addr] <= rx byte; pulse spi_wr_valid with addr and data on the next clk.
//     - In RD: byte discarded.
//   - Each SCLK fall: if bit_cnt == 0 (a byte just completed), load tx_shift; otherwise shift tx_shift left, filling with 0.
//     - In RD, the load value is regs[addr], sampled at that fall, so repeated reads track updates.
//     - In WR, the load value is 0x00.
//  Abort: ss_n rise in any state returns to IDLE next clk. A partial byte (bit_cnt != 0) is discarded, with no write and no pulse.
//  Local write: regs[loc_addr] <= loc_wdata on loc_we.
//   - Same-cycle collision with an SPI write to the same address: the SPI write wins and the local write is lost.
//   - Different addresses: both take effect.
//  irq updates one clk after any change to IRQ_REG or IEN_REG.
//  Reset asserted mid-transfer: immediate return to reset values.
//   - After release, the block waits for a fresh ss_n fall. A transfer already in progress with ss_n low is ignored until ss_n rises.
// TESTING
//  1. SPI write: ss low, send 0x2A (reg5, write), then 0xA5, ss high.
//     -> regs[5] = 0xA5, one spi_wr_valid pulse with addr = 5 and data = 0xA5; loc_rdata @5 = 0xA5.
//  2. Status and read: local-write regs[24] = 0x3C and regs[5] = 0x5A, then send 0x28 followed by 2 dummy bytes.
//     -> MISO bytes: 0x3C, 0x5A, 0x5A; no wr pulse.
//  3. Abort: send 0x2A, 4 data bits, ss high.
//     -> regs[5] unchanged, no pulse; next full transfer works.
//  4. Collision: SPI write to reg 7 with 0x11 completes in the same clk as loc_we to reg 7 with 0x22.
//     -> regs[7] = 0x11.
//  5. IRQ: local-write IEN = 0x04, then IRQ = 0x04 -> irq = 1 one clk later. SPI-write IRQ = 0x00 -> irq = 0.
//  6. Reset mid-byte: assert reset_reset during CMD bit 3.
//     -> all outputs and regs at reset values; a new ss cycle succeeds.

Source files
------------

// File: rtl/spi_reg_slave.sv
// SPI mode-0 responder with a 32x8 register file, MAX3421E-style framing.
// Command byte: reg = cmd[7:3], write when cmd[1]. The data bytes that follow
// go to or come from that one register (no auto-increment).
// All SPI pins are oversampled in the clk_clk domain. SCLK must be <= clk_clk/8.
module spi_reg_slave #(
    parameter logic [4:0] STATUS_REG = 5'd24,
    parameter logic [4:0] IRQ_REG    = 5'd25,
    parameter logic [4:0] IEN_REG    = 5'd26
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_ss_n,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [4:0] loc_addr,
    input  logic [7:0] loc_wdata,
    input  logic       loc_we,
    output logic [7:0] loc_rdata,
    output logic       spi_wr_valid,
    output logic [4:0] spi_wr_addr,
    output logic [7:0] spi_wr_data,
    output logic       irq
);

    typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

    state_t      state_q, state_d;
    logic [7:0]  regs [0:31];
    logic        sclk_s1, sclk_s2, sclk_d;
    logic        mosi_s1, mosi_s2;
    logic        ss_s1, ss_s2, ss_d;
    logic [1:0]  sync_vld;
    logic        armed;
    logic [7:0]  rx_shift, tx_shift;
    logic [2:0]  bit_cnt;
    logic [4:0]  addr;

    logic        sclk_rise, sclk_fall, ss_fall;
    logic [7:0]  rx_next;
    logic        start, active, shift_en, byte_done, spi_we, tx_load, tx_shift_en;

    // Two-flop synchronisers plus delayed copies for edge detection. ss_n
    // resets high so the bus looks deselected. The block is only armed once the
    // synchronised ss_n is seen high, so a select that is already low when
    // reset is released is ignored until it rises.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sclk_s1  <= 1'b0;
            sclk_s2  <= 1'b0;
            sclk_d   <= 1'b0;
            mosi_s1  <= 1'b0;
            mosi_s2  <= 1'b0;
            ss_s1    <= 1'b1;
            ss_s2    <= 1'b1;
            ss_d     <= 1'b1;
            sync_vld <= 2'b00;
            armed    <= 1'b0;
        end else begin
            sclk_s1  <= spi_sclk;
            sclk_s2  <= sclk_s1;
            sclk_d   <= sclk_s2;
            mosi_s1  <= spi_mosi;
            mosi_s2  <= mosi_s1;
            ss_s1    <= spi_ss_n;
            ss_s2    <= ss_s1;
            ss_d     <= ss_s2;
            sync_vld <= {sync_vld[0], 1'b1};
            armed    <= armed | (sync_vld[1] & ss_s2);
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign sclk_fall = ~sclk_s2 & sclk_d;
    assign ss_fall   = armed & ss_d & ~ss_s2;
    assign rx_next   = {rx_shift[6:0], mosi_s2};

    // State register.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // Next state: select starts a frame, deselect aborts from any state, and
    // the command byte chooses the write or read phase.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ss_fall) state_d = CMD;
            CMD: begin
                if (ss_s2)
                    state_d = IDLE;
                else if (sclk_rise && bit_cnt == 3'd7)
                    state_d = rx_next[1] ? WR : RD;
            end
            default: if (ss_s2) state_d = IDLE;
        endcase
    end

    // Datapath strobes decoded from the state. Nothing fires while deselected,
    // so a partial byte at abort never writes.
    always_comb begin
        start       = (state_q == IDLE) && ss_fall;
        active      = (state_q != IDLE) && !ss_s2;
        shift_en    = active && sclk_rise;
        byte_done   = shift_en && (bit_cnt == 3'd7);
        spi_we      = byte_done && (state_q == WR);
        tx_load     = active && sclk_fall && (bit_cnt == 3'd0);
        tx_shift_en = active && sclk_fall && (bit_cnt != 3'd0);
    end

    // Shift registers, bit counter, latched address and the write-report pulse.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            rx_shift     <= 8'h00;
            tx_shift     <= 8'h00;
            bit_cnt      <= 3'd0;
            addr         <= 5'd0;
            spi_wr_valid <= 1'b0;
            spi_wr_addr  <= 5'd0;
            spi_wr_data  <= 8'h00;
        end else begin
            spi_wr_valid <= spi_we;
            if (spi_we) begin
                spi_wr_addr <= addr;
                spi_wr_data <= rx_next;
            end
            if (start) begin
                tx_shift <= regs[STATUS_REG];
                bit_cnt  <= 3'd0;
            end else begin
                if (shift_en) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (byte_done && state_q == CMD)
                    addr <= rx_next[7:3];
                if (tx_load)
                    tx_shift <= (state_q == RD) ? regs[addr] : 8'h00;
                else if (tx_shift_en)
                    tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    // Register file. An SPI write beats a same-cycle local write to the same
    // register, but writes to different registers both take effect.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 8'h00;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (spi_we && addr == 5'(i))
                    regs[i] <= rx_next;
                else if (loc_we && loc_addr == 5'(i))
                    regs[i] <= loc_wdata;
            end
        end
    end

    // Registered interrupt output, one clk behind the flag/enable registers.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) irq <= 1'b0;
        else             irq <= |(regs[IRQ_REG] & regs[IEN_REG]);
    end

    assign spi_miso    = tx_shift[7];
    assign spi_miso_oe = ~ss_s2;
    assign loc_rdata   = regs[loc_addr];

endmodule
